coco_joy_scan_ctrl: RTL and testbench

// - Hardware joystick digitiser: owns the 6-bit DAC value and the SELB/SELA mux of trs80_dac.
// - Runs a 6-step successive-approximation compare per axis on hilo, for 4 axes.
// - Arbitrates the DAC between the CPU (PIA latch, sound) and the scanner. The CPU always has priority.
// - Sits between the PIA outputs and trs80_dac; results go to the joystick and debug readback logic.

---
 rtl/coco_dac_pkg.sv | 33 +++
 rtl/coco_joy_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_coco_joy_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/coco_dac_pkg.sv
// Shared definitions for the CoCo DAC / joystick scan logic.
// - SEL_JOY0..3: analog mux selects used while digitising joystick axes.
// - SND_*: the same mux viewed as the sound source select.
// - scan_state_t: scanner FSM states.
// - DAC_W, AXES: DAC resolution and number of joystick axes.
// - trial_bit(): one-hot trial mask for a successive-approximation bit index.
package coco_dac_pkg;

    localparam int unsigned DAC_W = 6;
    localparam int unsigned AXES  = 4;

    localparam logic [1:0] SEL_JOY0 = 2'b00;
    localparam logic [1:0] SEL_JOY1 = 2'b01;
    localparam logic [1:0] SEL_JOY2 = 2'b10;
    localparam logic [1:0] SEL_JOY3 = 2'b11;

    localparam logic [1:0] SND_DAC  = 2'b00;
    localparam logic [1:0] SND_CASS = 2'b01;
    localparam logic [1:0] SND_CART = 2'b10;
    localparam logic [1:0] SND_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DECIDE,
        DONE
    } scan_state_t;

    function automatic logic [DAC_W-1:0] trial_bit(input logic [2:0] b);
        return {{(DAC_W-1){1'b0}}, 1'b1} << b;
    endfunction

endpackage

// File: rtl/coco_joy_scan_ctrl.sv
// Hardware joystick digitiser. Owns the 6-bit DAC value and the SELB/SELA
// mux feeding trs80_dac, and runs a 6-step successive-approximation compare
// on hilo for each of the 4 joystick axes. The CPU always wins the DAC: a
// high snden cancels any scan in progress.
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   start              one-cycle scan request
//   cpu_dac, cpu_sel   DAC value and {selb,sela} from the PIA
//   snden              sound enable; high = CPU owns the DAC
//   hilo               registered comparator from trs80_dac (1 = joy >= dac)
//   dac_out, sel_out   to trs80_dac
//   busy               scanner owns the DAC
//   done, abort        one-cycle completion / cancellation pulses
//   axis_val           {axis3,axis2,axis1,axis0}, 6 bits each
//   valid              set by the first completed scan
module coco_joy_scan_ctrl
    import coco_dac_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned AUTO_PERIOD   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DAC_W-1:0]      cpu_dac,
    input  logic [1:0]            cpu_sel,
    input  logic                  snden,
    input  logic                  hilo,
    output logic [DAC_W-1:0]      dac_out,
    output logic [1:0]            sel_out,
    output logic                  busy,
    output logic                  done,
    output logic                  abort,
    output logic [AXES*DAC_W-1:0] axis_val,
    output logic                  valid
);

    localparam logic [7:0]       SettleLoad = 8'(SETTLE_CYCLES - 1);
    localparam bit               AutoEn     = (AUTO_PERIOD != 0);
    localparam logic [31:0]      AutoLast   = AutoEn ? 32'(AUTO_PERIOD - 1) : 32'd0;
    localparam logic [1:0]       LastAxis   = 2'(AXES - 1);
    localparam logic [2:0]       TopBit     = 3'(DAC_W - 1);
    localparam logic [DAC_W-1:0] FirstTrial = trial_bit(TopBit);

    scan_state_t            state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic                   valid_q, valid_d;
    logic                   pending_q, pending_d;
    logic [AXES*DAC_W-1:0]  axis_q, axis_d;
    logic [31:0]            auto_cnt_q, auto_cnt_d;
    logic [7:0]             settle_q, settle_d;
    logic [2:0]             bit_q, bit_d;
    logic [1:0]             axis_idx_q, axis_idx_d;
    logic [DAC_W-1:0]       acc_q, acc_d;
    logic [DAC_W-1:0]       trial_q, trial_d;

    logic                   auto_hit;
    logic                   req;
    logic [DAC_W-1:0]       bit_mask;
    logic [DAC_W-1:0]       acc_new;

    // Owner mux depends only on registered state, so reset hands the DAC
    // back to the CPU without waiting for a clock edge.
    assign dac_out  = owner_q ? trial_q : cpu_dac;
    assign sel_out  = owner_q ? axis_idx_q : cpu_sel;
    assign busy     = owner_q;
    assign done     = done_q;
    assign abort    = abort_q;
    assign axis_val = axis_q;
    assign valid    = valid_q;

    assign auto_hit = AutoEn && (auto_cnt_q == AutoLast);
    assign req      = start || auto_hit;
    assign bit_mask = trial_bit(bit_q);
    assign acc_new  = hilo ? (acc_q | bit_mask) : (acc_q & ~bit_mask);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        valid_d    = valid_q;
        pending_d  = pending_q;
        axis_d     = axis_q;
        auto_cnt_d = auto_cnt_q;
        settle_d   = settle_q;
        bit_d      = bit_q;
        axis_idx_d = axis_idx_q;
        acc_d      = acc_q;
        trial_d    = trial_q;

        if (AutoEn) begin
            auto_cnt_d = auto_hit ? 32'd0 : auto_cnt_q + 32'd1;
        end

        // Single-entry request slot: anything arriving while a request is
        // already held or a scan is running is dropped.
        if (req && !pending_q && !owner_q) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pending_q && !snden) begin
                    state_d    = SETTLE;
                    owner_d    = 1'b1;
                    pending_d  = 1'b0;
                    axis_idx_d = SEL_JOY0;
                    bit_d      = TopBit;
                    acc_d      = '0;
                    trial_d    = FirstTrial;
                    settle_d   = SettleLoad;
                end
            end
            SETTLE: begin
                if (snden) begin
                    state_d = IDLE;
                    owner_d = 1'b0;
                    abort_d = 1'b1;
                end else if (settle_q == 8'd0) begin
                    state_d = DECIDE;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            DECIDE: begin
                if (snden) begin
                    state_d = IDLE;
                    owner_d = 1'b0;
                    abort_d = 1'b1;
                end else if (bit_q != 3'd0) begin
                    acc_d    = acc_new;
                    bit_d    = bit_q - 3'd1;
                    trial_d  = acc_new | trial_bit(bit_q - 3'd1);
                    settle_d = SettleLoad;
                    state_d  = SETTLE;
                end else begin
                    axis_d[axis_idx_q*DAC_W +: DAC_W] = acc_new;
                    if (axis_idx_q != LastAxis) begin
                        axis_idx_d = axis_idx_q + 2'd1;
                        acc_d      = '0;
                        bit_d      = TopBit;
                        trial_d    = FirstTrial;
                        settle_d   = SettleLoad;
                        state_d    = SETTLE;
                    end else begin
                        // Release the DAC as the done pulse appears, so a
                        // late snden in DONE has nothing left to cancel.
                        acc_d   = acc_new;
                        state_d = DONE;
                        owner_d = 1'b0;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                owner_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            valid_q    <= 1'b0;
            pending_q  <= 1'b0;
            axis_q     <= '0;
            auto_cnt_q <= 32'd0;
            settle_q   <= 8'd0;
            bit_q      <= 3'd0;
            axis_idx_q <= 2'd0;
            acc_q      <= '0;
            trial_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
            axis_q     <= axis_d;
            auto_cnt_q <= auto_cnt_d;
            settle_q   <= settle_d;
            bit_q      <= bit_d;
            axis_idx_q <= axis_idx_d;
            acc_q      <= acc_d;
            trial_q    <= trial_d;
        end
    end

endmodule

// File: tb/tb_coco_joy_scan_ctrl.sv
// Bench for coco_joy_scan_ctrl with a behavioural trs80_dac comparator.
// Two instances: one manually started, one self-triggering every 100 clocks.
module tb_coco_joy_scan_ctrl;

    localparam int unsigned S   = 2;
    localparam int          LAT = 1 + 24 * (S + 1);
    localparam logic [23:0] EXP_T1 = {6'd31, 6'd32, 6'd0, 6'd63};

    logic        clk, reset, start, snden;
    logic [5:0]  cpu_dac;
    logic [1:0]  cpu_sel;
    logic [15:0] joya1, joya2;

    logic        hilo, busy, done, abort, valid;
    logic [5:0]  dac_out;
    logic [1:0]  sel_out;
    logic [23:0] axis_val;

    logic        hilo_a, busy_a, done_a, abort_a, valid_a;
    logic [5:0]  dac_out_a;
    logic [1:0]  sel_out_a;
    logic [23:0] axis_val_a;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    coco_joy_scan_ctrl #(.SETTLE_CYCLES(S), .AUTO_PERIOD(0)) dut (
        .clk(clk), .reset(reset), .start(start), .cpu_dac(cpu_dac), .cpu_sel(cpu_sel),
        .snden(snden), .hilo(hilo), .dac_out(dac_out), .sel_out(sel_out), .busy(busy),
        .done(done), .abort(abort), .axis_val(axis_val), .valid(valid)
    );

    coco_joy_scan_ctrl #(.SETTLE_CYCLES(S), .AUTO_PERIOD(100)) dut_a (
        .clk(clk), .reset(reset), .start(start), .cpu_dac(cpu_dac), .cpu_sel(cpu_sel),
        .snden(snden), .hilo(hilo_a), .dac_out(dac_out_a), .sel_out(sel_out_a),
        .busy(busy_a), .done(done_a), .abort(abort_a), .axis_val(axis_val_a),
        .valid(valid_a)
    );

    // Joystick wiring: sel 0/1 read joya2 high/low byte, sel 2/3 read joya1.
    function automatic logic [5:0] joy_field(input logic [15:0] j1, input logic [15:0] j2,
                                             input logic [1:0] s);
        case (s)
            2'd0:    return j2[15:10];
            2'd1:    return j2[7:2];
            2'd2:    return j1[15:10];
            default: return j1[7:2];
        endcase
    endfunction

    function automatic logic [23:0] exp_axes(input logic [15:0] j1, input logic [15:0] j2);
        return {joy_field(j1, j2, 2'd3), joy_field(j1, j2, 2'd2),
                joy_field(j1, j2, 2'd1), joy_field(j1, j2, 2'd0)};
    endfunction

    // trs80_dac comparator model: registered joy >= dac.
    always_ff @(posedge clk) begin
        hilo   <= joy_field(joya1, joya2, sel_out) >= dac_out;
        hilo_a <= joy_field(joya1, joya2, sel_out_a) >= dac_out_a;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; snden = 1'b0; cpu_dac = 6'h2A; cpu_sel = 2'b01;
        joya1 = 16'h807C; joya2 = 16'hFC00;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0 || abort !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", done, abort); end
        checks++; if (axis_val !== 24'd0 || valid !== 1'b0) begin errors++; $display("FAIL reset_result got %h/%b want 0/0", axis_val, valid); end
        checks++; if (dac_out !== 6'h2A || sel_out !== 2'b01) begin errors++; $display("FAIL reset_mux got %h/%b want 2a/01", dac_out, sel_out); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        logic [5:0] dv [4] = '{6'h00, 6'h3F, 6'h15, 6'h2A};
        for (int i = 0; i < 4; i++) begin
            cpu_dac = dv[i]; cpu_sel = 2'(i);
            #1;
            checks++;
            if (dac_out !== dv[i] || sel_out !== 2'(i)) begin
                errors++; $display("FAIL passthrough got %h/%b want %h/%b", dac_out, sel_out, dv[i], 2'(i));
            end
        end
    endtask

    task automatic test_full_scan();
        int n; bit seen; logic [23:0] e;
        joya1 = 16'h807C; joya2 = 16'hFC00;
        exp_q.push_back(EXP_T1);
        start = 1'b1; tick(); start = 1'b0;
        n = 0; seen = 0;
        while (n < 300 && !seen) begin
            tick(); n++;
            if (n == 1) begin
                checks++;
                if (busy !== 1'b1 || dac_out !== 6'd32 || sel_out !== 2'd0) begin
                    errors++; $display("FAIL scan_first_trial got %b/%0d/%0d want 1/32/0", busy, dac_out, sel_out);
                end
            end
            if (done === 1'b1) seen = 1;
        end
        checks++; if (!seen || n != LAT) begin errors++; $display("FAIL scan_latency got %0d (seen %0d) want %0d", n, seen, LAT); end
        e = exp_q.pop_front();
        checks++; if (axis_val !== e) begin errors++; $display("FAIL scan_axes got %h want %h", axis_val, e); end
        checks++; if (valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL scan_flags got valid %b busy %b want 1/0", valid, busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL scan_done_width got %b want 0", done); end
    endtask

    task automatic test_trial_sequence();
        int n; bit seen; logic [5:0] got[$]; logic [23:0] e;
        logic [5:0] trials [6] = '{6'd32, 6'd48, 6'd40, 6'd36, 6'd34, 6'd33};
        exp_q.push_back(exp_axes(joya1, joya2));
        start = 1'b1; tick(); start = 1'b0;
        n = 0; seen = 0;
        while (n < 300 && !seen) begin
            tick(); n++;
            if (busy === 1'b1 && sel_out === 2'b10) got.push_back(dac_out);
            if (done === 1'b1) seen = 1;
        end
        checks++; if (!seen || got.size() != 18) begin errors++; $display("FAIL trial_count got %0d want 18", got.size()); end
        for (int i = 0; i < got.size() && i < 18; i++) begin
            checks++;
            if (got[i] !== trials[i/3]) begin errors++; $display("FAIL trial_seq[%0d] got %0d want %0d", i, got[i], trials[i/3]); end
        end
        e = exp_q.pop_front();
        checks++; if (axis_val !== e) begin errors++; $display("FAIL trial_axes got %h want %h", axis_val, e); end
    endtask

    task automatic test_abort();
        int n; bit seen;
        cpu_dac = 6'h15; cpu_sel = 2'b11;
        start = 1'b1; tick(); start = 1'b0;
        n = 0; seen = 0;
        while (n < 300 && !seen) begin
            tick(); n++;
            if (busy === 1'b1 && sel_out === 2'd1) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL abort_reach_axis1 got timeout want sel 1"); end
        tick(); tick(); tick();
        snden = 1'b1;
        tick();
        checks++; if (abort !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_pulse got abort %b busy %b want 1/0", abort, busy); end
        checks++; if (dac_out !== 6'h15 || sel_out !== 2'b11) begin errors++; $display("FAIL abort_mux got %h/%b want 15/11", dac_out, sel_out); end
        checks++; if (axis_val !== EXP_T1 || valid !== 1'b1) begin errors++; $display("FAIL abort_keep got %h/%b want %h/1", axis_val, valid, EXP_T1); end
        tick();
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL abort_width got %b want 0", abort); end
        snden = 1'b0;
        tick(); tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_no_restart got busy %b want 0", busy); end
    endtask

    task automatic test_deferred();
        int n; bit seen; int busy_seen; logic [23:0] e;
        joya1 = 16'h2CA8; joya2 = 16'h6414;
        snden = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (busy === 1'b1) busy_seen++;
        end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL deferred_hold got %0d busy clocks want 0", busy_seen); end
        exp_q.push_back(exp_axes(joya1, joya2));
        snden = 1'b0;
        n = 0; seen = 0;
        while (n < 300 && !seen) begin
            tick(); n++;
            if (n == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL deferred_start got busy %b want 1", busy); end
            end
            if (done === 1'b1) seen = 1;
        end
        checks++; if (!seen || n != LAT) begin errors++; $display("FAIL deferred_latency got %0d want %0d", n, LAT); end
        e = exp_q.pop_front();
        checks++; if (axis_val !== e) begin errors++; $display("FAIL deferred_axes got %h want %h", axis_val, e); end
    endtask

    task automatic test_back_to_back();
        int n; bit seen; int busy_seen; logic [23:0] e;
        joya1 = 16'hFFFF; joya2 = 16'h0000;
        exp_q.push_back(exp_axes(joya1, joya2));
        start = 1'b1; tick(); start = 1'b0;
        n = 0; seen = 0;
        while (n < 300 && !seen) begin
            tick(); n++;
            start = (n == 20);
            if (done === 1'b1) seen = 1;
        end
        start = 1'b0;
        checks++; if (!seen || n != LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", n, LAT); end
        e = exp_q.pop_front();
        checks++; if (axis_val !== e) begin errors++; $display("FAIL b2b_axes got %h want %h", axis_val, e); end
        snden = 1'b1;  // arrives with the done pulse: must not abort
        tick();
        checks++; if (abort !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL done_vs_snden got abort %b valid %b want 0/1", abort, valid); end
        snden = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (busy === 1'b1) busy_seen++;
        end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL b2b_dropped got %0d busy clocks want 0", busy_seen); end
    endtask

    task automatic test_reset_mid_scan();
        int n; bit seen; logic [23:0] e;
        cpu_dac = 6'h0F; cpu_sel = 2'b10;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || axis_val !== 24'd0) begin errors++; $display("FAIL rst_mid got busy %b valid %b axes %h want 0/0/0", busy, valid, axis_val); end
        checks++; if (dac_out !== 6'h0F || sel_out !== 2'b10) begin errors++; $display("FAIL rst_mid_mux got %h/%b want 0f/10", dac_out, sel_out); end
        tick(); reset = 1'b0; tick();
        joya1 = 16'h807C; joya2 = 16'hFC00;
        exp_q.push_back(EXP_T1);
        start = 1'b1; tick(); start = 1'b0;
        n = 0; seen = 0;
        while (n < 300 && !seen) begin
            tick(); n++;
            if (done === 1'b1) seen = 1;
        end
        checks++; if (!seen || n != LAT) begin errors++; $display("FAIL rst_rescan_latency got %0d want %0d", n, LAT); end
        e = exp_q.pop_front();
        checks++; if (axis_val !== e || valid !== 1'b1) begin errors++; $display("FAIL rst_rescan_axes got %h/%b want %h/1", axis_val, valid, e); end
    endtask

    task automatic test_auto();
        int last; int cnt;
        joya1 = 16'h807C; joya2 = 16'hFC00; snden = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        last = 0; cnt = 0;
        for (int n = 1; n <= 480; n++) begin
            tick();
            start = (n == 220);
            if (done_a === 1'b1) begin
                cnt++;
                checks++;
                if (cnt == 1 && n != 173) begin errors++; $display("FAIL auto_first got %0d want 173", n); end
                else if (cnt > 1 && n - last != 100) begin errors++; $display("FAIL auto_period got %0d want 100", n - last); end
                checks++;
                if (axis_val_a !== EXP_T1) begin errors++; $display("FAIL auto_axes got %h want %h", axis_val_a, EXP_T1); end
                last = n;
            end
        end
        start = 1'b0;
        checks++; if (cnt != 4) begin errors++; $display("FAIL auto_count got %0d want 4", cnt); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_full_scan();
        test_trial_sequence();
        test_abort();
        test_deferred();
        test_back_to_back();
        test_reset_mid_scan();
        test_auto();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
